// File: rtl/pbl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pbl_pkg
//  Description : Shared types and codes for the two-terminal arbiter:
//                terminal FSM states, owner codes, terminal select codes
//                and the code driven to a decoder whose terminal is idle.
//  Revision    : 1.0 - initial release
// ============================================================================
package pbl_pkg;

  // Terminal FSM states. The encoding matches the owner code so the
  // owner output is a direct view of the state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

  // Owner codes seen on OWN_MATRIZ / OWN_LEDS
  localparam logic [1:0] C_OWN_NONE = 2'b00;
  localparam logic [1:0] C_OWN_U0   = 2'b01;
  localparam logic [1:0] C_OWN_U1   = 2'b10;

  // Terminal select codes carried on SEL0 / SEL1
  localparam logic C_TERM_MATRIZ = 1'b0;
  localparam logic C_TERM_LEDS   = 1'b1;

  // Functionality code routed to a decoder nobody owns
  localparam logic [2:0] C_CF_IDLE = 3'b000;

  // Authentication level meaning "not authenticated"
  localparam logic [2:0] C_AUT_NONE = 3'b000;

  // Owner code corresponding to an FSM state
  function automatic logic [1:0] owner_code(input arb_state_e st);
    case (st)
      ST_OWN0: owner_code = C_OWN_U0;
      ST_OWN1: owner_code = C_OWN_U1;
      default: owner_code = C_OWN_NONE;
    endcase
  endfunction

  // Functionality code routed for a given owner code
  function automatic logic [2:0] route_cf(input logic [1:0] owner,
                                          input logic [2:0] cf0,
                                          input logic [2:0] cf1);
    case (owner)
      C_OWN_U0: route_cf = cf0;
      C_OWN_U1: route_cf = cf1;
      default:  route_cf = C_CF_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_terminal.sv
`default_nettype none
// ============================================================================
//  Module      : arbitro_terminal
//  Description : Arbiter for a single terminal. One FSM (IDLE/OWN0/OWN1),
//                a minimum-hold counter and a round-robin pointer used to
//                break ties between equally authenticated users.
//                Optional macro ARB_PREEMPT_EN: a contender with strictly
//                higher authentication steals the terminal immediately,
//                ignoring the hold counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module arbitro_terminal
  import pbl_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_elig0,
  input  logic       i_elig1,
  input  logic [2:0] i_aut0,
  input  logic [2:0] i_aut1,
  output logic [1:0] o_owner,
  output logic [1:0] o_owner_nxt
);

  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD_ONE  = CNT_W'(1);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_hold;
  logic             r_pref;        // 1 = user 1 wins the next tie
  logic             w_hold_done;
  logic             w_enter;       // a new owner takes the terminal
  logic             w_preempt0;    // user 0 may steal from owner 1
  logic             w_preempt1;    // user 1 may steal from owner 0

  assign w_hold_done = (r_hold == '0);

`ifdef ARB_PREEMPT_EN
  assign w_preempt0 = i_elig0 && (i_aut0 > i_aut1);
  assign w_preempt1 = i_elig1 && (i_aut1 > i_aut0);
`else
  assign w_preempt0 = 1'b0;
  assign w_preempt1 = 1'b0;
`endif

  // Next-state decision: grant from idle, release, hold-expiry handover
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_elig0 && i_elig1) begin
          if (i_aut0 > i_aut1) begin
            w_state_nxt = ST_OWN0;
          end else if (i_aut1 > i_aut0) begin
            w_state_nxt = ST_OWN1;
          end else begin
            w_state_nxt = r_pref ? ST_OWN1 : ST_OWN0;
          end
        end else if (i_elig0) begin
          w_state_nxt = ST_OWN0;
        end else if (i_elig1) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!i_elig0) begin
          w_state_nxt = i_elig1 ? ST_OWN1 : ST_IDLE;
        end else if (i_elig1 && (w_hold_done || w_preempt1)) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!i_elig1) begin
          w_state_nxt = i_elig0 ? ST_OWN0 : ST_IDLE;
        end else if (i_elig0 && (w_hold_done || w_preempt0)) begin
          w_state_nxt = ST_OWN0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);

  // State, hold counter and tie-break pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_pref  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter) begin
        // the new owner must not win the next tie on this terminal
        r_hold <= C_HOLD_LOAD;
        r_pref <= (w_state_nxt == ST_OWN0);
      end else if (w_state_nxt == ST_IDLE) begin
        r_hold <= '0;
      end else if (!w_hold_done) begin
        r_hold <= r_hold - C_HOLD_ONE;
      end
    end
  end

  assign o_owner     = owner_code(r_state);
  assign o_owner_nxt = owner_code(w_state_nxt);

endmodule
`default_nettype wire

// File: rtl/arbitro_terminais.sv
`default_nettype none
// ============================================================================
//  Module      : arbitro_terminais
//  Description : Two-user, two-terminal arbiter (matrix and LEDs). Decodes
//                per-terminal eligibility, runs one arbitro_terminal per
//                terminal, and registers the routed functionality codes and
//                the per-user grant flags.
//                Optional macro ARB_PREEMPT_EN (see arbitro_terminal).
//  Revision    : 1.0 - initial release
// ============================================================================
module arbitro_terminais
  import pbl_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [2:0] AUT0,
  input  logic [2:0] AUT1,
  input  logic       SEL0,
  input  logic       SEL1,
  input  logic [2:0] CF0,
  input  logic [2:0] CF1,
  output logic [2:0] FMATRIZ,
  output logic [2:0] FLEDS,
  output logic       GNT0,
  output logic       GNT1,
  output logic [1:0] OWN_MATRIZ,
  output logic [1:0] OWN_LEDS
);

  logic       w_auth0;
  logic       w_auth1;
  logic       w_elig0_m;
  logic       w_elig1_m;
  logic       w_elig0_l;
  logic       w_elig1_l;
  logic [1:0] w_nxt_m;
  logic [1:0] w_nxt_l;
  logic [2:0] r_fmatriz;
  logic [2:0] r_fleds;
  logic       r_gnt0;
  logic       r_gnt1;

  assign w_auth0 = REQ0 && (AUT0 != C_AUT_NONE);
  assign w_auth1 = REQ1 && (AUT1 != C_AUT_NONE);

  // A user is eligible only for the terminal its SEL points at, so the
  // same user can never be owner of both terminals at once.
  assign w_elig0_m = w_auth0 && (SEL0 == C_TERM_MATRIZ);
  assign w_elig1_m = w_auth1 && (SEL1 == C_TERM_MATRIZ);
  assign w_elig0_l = w_auth0 && (SEL0 == C_TERM_LEDS);
  assign w_elig1_l = w_auth1 && (SEL1 == C_TERM_LEDS);

  arbitro_terminal #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_matriz (
    .clk         (CLK),
    .rst         (RST),
    .i_elig0     (w_elig0_m),
    .i_elig1     (w_elig1_m),
    .i_aut0      (AUT0),
    .i_aut1      (AUT1),
    .o_owner     (OWN_MATRIZ),
    .o_owner_nxt (w_nxt_m)
  );

  arbitro_terminal #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_leds (
    .clk         (CLK),
    .rst         (RST),
    .i_elig0     (w_elig0_l),
    .i_elig1     (w_elig1_l),
    .i_aut0      (AUT0),
    .i_aut1      (AUT1),
    .o_owner     (OWN_LEDS),
    .o_owner_nxt (w_nxt_l)
  );

  // Route the incoming owner's code and grant flags, aligned with OWN_*
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fmatriz <= C_CF_IDLE;
      r_fleds   <= C_CF_IDLE;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
    end else begin
      r_fmatriz <= route_cf(w_nxt_m, CF0, CF1);
      r_fleds   <= route_cf(w_nxt_l, CF0, CF1);
      r_gnt0    <= (w_nxt_m == C_OWN_U0) || (w_nxt_l == C_OWN_U0);
      r_gnt1    <= (w_nxt_m == C_OWN_U1) || (w_nxt_l == C_OWN_U1);
    end
  end

  assign FMATRIZ = r_fmatriz;
  assign FLEDS   = r_fleds;
  assign GNT0    = r_gnt0;
  assign GNT1    = r_gnt1;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_terminais.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbitro_terminais
//  Description : Self-checking bench for arbitro_terminais. A per-user,
//                per-terminal behavioural model predicts the outputs every
//                cycle; directed scenarios add literal expectations.
//                Honours ARB_PREEMPT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_terminais;

  localparam int HOLD = 8;
`ifdef ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req [2];
  logic [2:0] aut [2];
  logic       sel [2];
  logic [2:0] cf  [2];

  logic [2:0] FMATRIZ, FLEDS;
  logic       GNT0, GNT1;
  logic [1:0] OWN_MATRIZ, OWN_LEDS;

  int n_cmp  = 0;
  int n_fail = 0;

  // model: owner index per terminal (-1 none), cycles held, favoured user
  int         m_own [2];
  int         m_age [2];
  int         m_fav [2];
  logic [2:0] m_f   [2];

  arbitro_terminais #(
    .HOLD_CYCLES (HOLD),
    .CNT_W       (8)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ0       (req[0]),
    .REQ1       (req[1]),
    .AUT0       (aut[0]),
    .AUT1       (aut[1]),
    .SEL0       (sel[0]),
    .SEL1       (sel[1]),
    .CF0        (cf[0]),
    .CF1        (cf[1]),
    .FMATRIZ    (FMATRIZ),
    .FLEDS      (FLEDS),
    .GNT0       (GNT0),
    .GNT1       (GNT1),
    .OWN_MATRIZ (OWN_MATRIZ),
    .OWN_LEDS   (OWN_LEDS)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] code(input int o);
    if (o < 0) return 8'd0;
    return (o == 0) ? 8'd1 : 8'd2;
  endfunction

  // Behavioural model, evaluated on each rising edge
  always @(posedge clk) begin : model
    bit el [2];
    int cur, oth, nw;
    if (rst) begin
      for (int t = 0; t < 2; t++) begin
        m_own[t] = -1; m_age[t] = 0; m_fav[t] = 0; m_f[t] = 3'd0;
      end
    end else begin
      for (int t = 0; t < 2; t++) begin
        for (int u = 0; u < 2; u++)
          el[u] = req[u] && (aut[u] != 3'd0) && (sel[u] == (t == 1));
        cur = m_own[t];
        if (cur < 0) begin
          if (el[0] && el[1])
            nw = (aut[0] > aut[1]) ? 0 : (aut[1] > aut[0]) ? 1 : m_fav[t];
          else if (el[0]) nw = 0;
          else if (el[1]) nw = 1;
          else nw = -1;
        end else begin
          oth = 1 - cur;
          if (!el[cur]) nw = el[oth] ? oth : -1;
          else if (el[oth] && (m_age[t] >= HOLD - 1 || (PRE && aut[oth] > aut[cur]))) nw = oth;
          else nw = cur;
        end
        if (nw >= 0 && nw != cur) begin
          m_age[t] = 0;
          m_fav[t] = 1 - nw;
        end else if (nw >= 0) begin
          m_age[t]++;
        end
        m_own[t] = nw;
        m_f[t]   = (nw < 0) ? 3'd0 : cf[nw];
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    check("cmp_own_matriz", 8'(OWN_MATRIZ), code(m_own[0]));
    check("cmp_own_leds",   8'(OWN_LEDS),   code(m_own[1]));
    check("cmp_fmatriz",    8'(FMATRIZ),    8'(m_f[0]));
    check("cmp_fleds",      8'(FLEDS),      8'(m_f[1]));
    check("cmp_gnt0", 8'(GNT0), 8'((m_own[0] == 0) || (m_own[1] == 0)));
    check("cmp_gnt1", 8'(GNT1), 8'((m_own[0] == 1) || (m_own[1] == 1)));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; aut[u] = 3'd0; sel[u] = 1'b0; cf[u] = 3'd0;
    end
  endtask

  initial begin
    clear();
    rst = 1'b1;
    cyc(2);
    check("rst_own_m", 8'(OWN_MATRIZ), 8'h00);
    check("rst_own_l", 8'(OWN_LEDS),   8'h00);
    check("rst_fm",    8'(FMATRIZ),    8'h00);
    check("rst_fl",    8'(FLEDS),      8'h00);
    check("rst_gnt0",  8'(GNT0),       8'h00);
    check("rst_gnt1",  8'(GNT1),       8'h00);
    rst = 1'b0;
    cyc(1);

    // single requester on the matrix
    req[0] = 1'b1; aut[0] = 3'b011; sel[0] = 1'b0; cf[0] = 3'b101;
    cyc(1);
    check("single_own_m", 8'(OWN_MATRIZ), 8'h01);
    check("single_fm",    8'(FMATRIZ),    8'h05);
    check("single_gnt0",  8'(GNT0),       8'h01);
    check("single_fl",    8'(FLEDS),      8'h00);
    cf[0] = 3'b010;
    cyc(1);
    check("live_cf_fm", 8'(FMATRIZ), 8'h02);
    clear();
    cyc(1);
    check("release_own_m", 8'(OWN_MATRIZ), 8'h00);
    check("release_fm",    8'(FMATRIZ),    8'h00);

    // higher authentication wins, handover after the hold time
    req[0] = 1'b1; aut[0] = 3'b010; cf[0] = 3'd1;
    req[1] = 1'b1; aut[1] = 3'b110; cf[1] = 3'd7;
    cyc(1);
    check("prio_own_m", 8'(OWN_MATRIZ), 8'h02);
    check("prio_fm",    8'(FMATRIZ),    8'h07);
    check("prio_gnt0",  8'(GNT0),       8'h00);
    cyc(HOLD - 1);
    check("hold_still_u1", 8'(OWN_MATRIZ), 8'h02);
    cyc(1);
    check("hold_handover", 8'(OWN_MATRIZ), 8'h01);
    check("hold_fm",       8'(FMATRIZ),    8'h01);
    clear();
    cyc(1);

    // equal authentication, round robin on the LEDs
    req[0] = 1'b1; aut[0] = 3'b100; sel[0] = 1'b1; cf[0] = 3'd3;
    req[1] = 1'b1; aut[1] = 3'b100; sel[1] = 1'b1; cf[1] = 3'd6;
    cyc(1);
    check("rr1_own_l", 8'(OWN_LEDS), 8'h01);
    check("rr1_fl",    8'(FLEDS),    8'h03);
    req[0] = 1'b0; req[1] = 1'b0;
    cyc(1);
    check("rr_idle_l", 8'(OWN_LEDS), 8'h00);
    req[0] = 1'b1; req[1] = 1'b1;
    cyc(1);
    check("rr2_own_l", 8'(OWN_LEDS), 8'h02);
    check("rr2_fl",    8'(FLEDS),    8'h06);
    clear();
    cyc(1);

    // users on different terminals, then user 0 moves to the LEDs
    req[0] = 1'b1; aut[0] = 3'd1; sel[0] = 1'b0; cf[0] = 3'd4;
    req[1] = 1'b1; aut[1] = 3'd2; sel[1] = 1'b1; cf[1] = 3'd5;
    cyc(1);
    check("dual_own_m", 8'(OWN_MATRIZ), 8'h01);
    check("dual_own_l", 8'(OWN_LEDS),   8'h02);
    check("dual_gnt0",  8'(GNT0),       8'h01);
    check("dual_gnt1",  8'(GNT1),       8'h01);
    check("dual_fm",    8'(FMATRIZ),    8'h04);
    check("dual_fl",    8'(FLEDS),      8'h05);
    sel[0] = 1'b1;
    cyc(1);
    check("move_own_m", 8'(OWN_MATRIZ), 8'h00);
    check("move_own_l", 8'(OWN_LEDS),   8'h02);
    check("move_gnt0",  8'(GNT0),       8'h00);
    clear();
    cyc(1);

    // owner drops its request while the other user waits
    req[0] = 1'b1; aut[0] = 3'd1; sel[0] = 1'b0; cf[0] = 3'd2;
    cyc(1);
    check("drop_grant", 8'(OWN_MATRIZ), 8'h01);
    req[1] = 1'b1; aut[1] = 3'd1; sel[1] = 1'b0; cf[1] = 3'd3;
    cyc(2);
    check("drop_wait", 8'(OWN_MATRIZ), 8'h01);
    req[0] = 1'b0;
    cyc(1);
    check("drop_handover", 8'(OWN_MATRIZ), 8'h02);
    check("drop_fm",       8'(FMATRIZ),    8'h03);
    check("drop_gnt1",     8'(GNT1),       8'h01);
    clear();
    cyc(1);

    // much higher authentication arrives during the hold time
    req[0] = 1'b1; aut[0] = 3'b001; sel[0] = 1'b0;
    cyc(1);
    req[1] = 1'b1; aut[1] = 3'b111; sel[1] = 1'b0;
    cyc(1);
    check("preempt_own_m", 8'(OWN_MATRIZ), PRE ? 8'h02 : 8'h01);
    clear();
    cyc(1);

    // reset during ownership, then user 0 favoured again
    req[0] = 1'b1; aut[0] = 3'd4; sel[0] = 1'b0; cf[0] = 3'd6;
    req[1] = 1'b1; aut[1] = 3'd4; sel[1] = 1'b1; cf[1] = 3'd5;
    cyc(1);
    check("pre_rst_own_m", 8'(OWN_MATRIZ), 8'h01);
    check("pre_rst_own_l", 8'(OWN_LEDS),   8'h02);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_own_m", 8'(OWN_MATRIZ), 8'h00);
    check("mid_rst_own_l", 8'(OWN_LEDS),   8'h00);
    check("mid_rst_fm",    8'(FMATRIZ),    8'h00);
    check("mid_rst_fl",    8'(FLEDS),      8'h00);
    check("mid_rst_gnt0",  8'(GNT0),       8'h00);
    check("mid_rst_gnt1",  8'(GNT1),       8'h00);
    sel[1] = 1'b0;
    cyc(1);
    check("held_rst_own_m", 8'(OWN_MATRIZ), 8'h00);
    rst = 1'b0;
    cyc(1);
    check("post_rst_own_m", 8'(OWN_MATRIZ), 8'h01);
    check("post_rst_fm",    8'(FMATRIZ),    8'h06);
    clear();
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arbitro_terminais.md
ARBITRO_TERMINAIS -- requirements
Module: arbitro_terminais

Interface
REQ-001 Parameter HOLD_CYCLES, default 8, is the minimum number of cycles an owner keeps a contested terminal; legal range 1..255.
REQ-002 Parameter CNT_W, default 8, is the hold-counter width and SHALL satisfy 2^CNT_W > HOLD_CYCLES.
REQ-003 Port CLK, input, 1 bit, is the single clock; all state changes on the rising edge.
REQ-004 Port RST, input, 1 bit, is the reset: synchronous, active-high.
REQ-005 Ports REQ0 and REQ1, input, 1 bit each, are the request-valid signals for user 0 and user 1.
REQ-006 Ports AUT0 and AUT1, input, 3 bits each, give the authentication level (000 = none, 111 = highest).
REQ-007 Ports SEL0 and SEL1, input, 1 bit each, select the requested terminal (0 = matrix, 1 = LEDs).
REQ-008 Ports CF0 and CF1, input, 3 bits each, are the encoded functionality codes.
REQ-009 Ports FMATRIZ and FLEDS, output, 3 bits each, carry the code routed to the matrix and LED decoders.
REQ-010 Ports GNT0 and GNT1, output, 1 bit each, are high while that user owns any terminal.
REQ-011 Ports OWN_MATRIZ and OWN_LEDS, output, 2 bits each, give the terminal owner (00 = none, 01 = user 0, 10 = user 1).

Function
REQ-012 A user is eligible for terminal T when REQx=1, AUTx!=000 and SELx selects T.
REQ-013 Each terminal SHALL run an independent FSM with states IDLE, OWN0 and OWN1.
REQ-014 From IDLE with one eligible user, the FSM enters that user's OWN state at the next edge (1-cycle grant latency).
REQ-015 From IDLE with both users eligible, the higher AUT wins; on equal AUT, the user that did not win this terminal last wins (round-robin, user 0 after reset).
REQ-016 On entering OWNx, the hold counter loads HOLD_CYCLES-1, decrements each cycle and saturates at 0.
REQ-017 In OWNx, if the owner becomes ineligible (REQ drop, SEL change or AUT=000), the FSM moves at the next edge to the other user's OWN state when that user is eligible, otherwise to IDLE.
REQ-018 In OWNx with the counter at 0 and the other user eligible, the FSM hands over directly to the other OWN state with no idle cycle.
REQ-019 In OWNx with the counter at 0 and no contender, the owner keeps the terminal indefinitely.
REQ-020 Outputs are registered: FMATRIZ/FLEDS carry the owner's CF sampled at the previous edge (1-cycle latency, live updates while owning), and are 000 when the terminal is IDLE.
REQ-021 Both terminals may be owned at once, by different users or by the same user only if SEL toggles (a user is never listed as owner of both terminals simultaneously).
REQ-022 GNTx = (OWN_MATRIZ==x) OR (OWN_LEDS==x), registered consistently with the OWN outputs.

Reset
REQ-023 While RST=1 at an edge: both FSMs go to IDLE, counters are cleared, round-robin pointers favour user 0, and all outputs are 0 at the next edge.
REQ-024 Reset asserted mid-ownership aborts ownership without handover; arbitration restarts from IDLE on the first edge with RST=0.

Configuration
REQ-025 Macro ARB_PREEMPT_EN: when defined, an eligible contender with strictly higher AUT than the current owner takes the terminal at the next edge, regardless of the hold counter.
REQ-026 When ARB_PREEMPT_EN is undefined, the hold rule of REQ-018 applies at all AUT levels.

Structure
REQ-027 Package pbl_pkg holds the FSM state enum, the owner codes 00/01/10, terminal codes MATRIZ=0/LEDS=1, and the IDLE output code 000.
REQ-028 Sub-module arbitro_terminal (one FSM, hold counter and RR pointer) is instantiated twice, once for the matrix and once for the LEDs; the top level does only eligibility decode, output muxing and the GNT OR.

Verification
REQ-029 Directed: REQ0=1, AUT0=011, SEL0=0, CF0=101 from IDLE -> next edge OWN_MATRIZ=01, FMATRIZ=101, GNT0=1, FLEDS=000.
REQ-030 Directed: both users request the matrix, AUT0=010, AUT1=110 -> OWN_MATRIZ=10; with HOLD_CYCLES=8 and both held, handover to 01 occurs exactly 8 cycles after the grant.
REQ-031 Directed: equal AUT=100, both users request the LEDs, twice from IDLE -> first grant to 01, second to 10.
REQ-032 Directed: users on different terminals (SEL0=0, SEL1=1) -> same-edge OWN_MATRIZ=01 and OWN_LEDS=10, GNT0=GNT1=1.
REQ-033 Directed: owner 01 drops REQ0 at cycle 3 while user 1 waits -> next edge OWN=10, no IDLE cycle; with ARB_PREEMPT_EN, AUT1=111 against AUT0=001 -> takeover at the next edge.
REQ-034 Directed: RST=1 during OWN1 -> next edge all outputs 0; first grant after release follows user-0 priority.
